// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, redirect/stall handling and IF/ID capture for the MIPS fetch stage
module fetch_controller #(
  parameter int                    MEMORY_DEPTH = 256,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP          = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  BranchTaken,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic                  Jump,
  input  logic [DATA_WIDTH-1:0] JumpTarget,
  input  logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] ProgramAddress,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] IFID_Instruction,
  output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic                  Halted,
  output logic [15:0]           FetchCount
);

  localparam logic [DATA_WIDTH-1:0] IMAGE_BYTES = DATA_WIDTH'(MEMORY_DEPTH * 4);
  localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(4);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   pc_next, inst_next, pcp4_next;
  logic                    valid_next;
  logic [15:0]             count_next;

  // Lower bound first so the subtraction below can never wrap.
  function automatic logic in_image(input logic [DATA_WIDTH-1:0] addr);
    return (addr >= TEXT_BASE) && ((addr - TEXT_BASE) < IMAGE_BYTES);
  endfunction

  assign ProgramAddress = PC - TEXT_BASE;
  assign Halted         = (state == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= BOOT;
      PC               <= TEXT_BASE;
      IFID_Instruction <= NOP;
      IFID_PCPlus4     <= '0;
      IFID_Valid       <= 1'b0;
      FetchCount       <= '0;
    end else begin
      state            <= state_next;
      PC               <= pc_next;
      IFID_Instruction <= inst_next;
      IFID_PCPlus4     <= pcp4_next;
      IFID_Valid       <= valid_next;
      FetchCount       <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = PC;
    inst_next  = IFID_Instruction;
    pcp4_next  = IFID_PCPlus4;
    valid_next = IFID_Valid;
    count_next = FetchCount;
    case (state)
      BOOT: begin
        state_next = RUN;
        inst_next  = NOP;
        pcp4_next  = '0;
        valid_next = 1'b0;
      end
      RUN: begin
        if (BranchTaken) begin
          pc_next    = BranchTarget;
          inst_next  = NOP;
          pcp4_next  = '0;
          valid_next = 1'b0;
        end else if (Jump && !Stall) begin
          pc_next    = JumpTarget;
          inst_next  = NOP;
          pcp4_next  = '0;
          valid_next = 1'b0;
        end else if (!in_image(PC)) begin
          state_next = HALT;
          inst_next  = NOP;
          pcp4_next  = '0;
          valid_next = 1'b0;
        end else if (!Stall) begin
          pc_next    = PC + PC_STEP;
          inst_next  = Instruction;
          pcp4_next  = PC + PC_STEP;
          valid_next = 1'b1;
          count_next = (FetchCount == 16'hFFFF) ? FetchCount : FetchCount + 16'd1;
        end
      end
      HALT: begin
        // Only an EX-stage branch can restart fetch; an out-of-image target keeps us parked.
        inst_next  = NOP;
        pcp4_next  = '0;
        valid_next = 1'b0;
        if (BranchTaken) begin
          pc_next = BranchTarget;
          if (in_image(BranchTarget)) state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller against a behavioural fetch model
module tb_fetch_controller;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] LIMIT = 32'h0040_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget, Instruction;
  logic [31:0] ProgramAddress, PC, IFID_Instruction, IFID_PCPlus4;
  logic        IFID_Valid, Halted;
  logic [15:0] FetchCount;

  logic [31:0] rom [256];

  int checks = 0;
  int failures = 0;

  logic        m_boot, m_halt, m_valid;
  logic [31:0] m_pc, m_inst, m_pcp4;
  logic [15:0] m_cnt;

  fetch_controller dut (
    .clk(clk), .reset(reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Instruction(Instruction), .ProgramAddress(ProgramAddress), .PC(PC),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .Halted(Halted), .FetchCount(FetchCount)
  );

  always #5 clk = ~clk;

  assign Instruction = rom[ProgramAddress[9:2]];

  function automatic logic inside_image(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0;
    m_pc = BASE; m_inst = 32'h0; m_pcp4 = 32'h0; m_cnt = 16'h0;
  endtask

  task automatic model_bubble();
    m_inst = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic br, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt);
    if (m_boot) begin
      m_boot = 1'b0;
      model_bubble();
    end else if (m_halt) begin
      model_bubble();
      if (br) begin
        m_pc = bt;
        m_halt = !inside_image(bt);
      end
    end else if (br) begin
      m_pc = bt;
      model_bubble();
    end else if (j && !st) begin
      m_pc = jt;
      model_bubble();
    end else if (!inside_image(m_pc)) begin
      m_halt = 1'b1;
      model_bubble();
    end else if (!st) begin
      m_inst = rom[(m_pc - BASE) >> 2];
      m_pcp4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, PC, m_pc);
    chk({tag, ".paddr"}, ProgramAddress, m_pc - BASE);
    chk({tag, ".valid"}, 32'(IFID_Valid), 32'(m_valid));
    chk({tag, ".instr"}, IFID_Instruction, m_inst);
    if (m_valid) chk({tag, ".pcp4"}, IFID_PCPlus4, m_pcp4);
    chk({tag, ".halted"}, 32'(Halted), 32'(m_halt));
    chk({tag, ".count"}, 32'(FetchCount), 32'(m_cnt));
  endtask

  task automatic step(input string tag, input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    Stall = st; BranchTaken = br; BranchTarget = bt; Jump = j; JumpTarget = jt;
    @(posedge clk);
    model_edge(st, br, bt, j, jt);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".pc"}, PC, BASE);
    chk({tag, ".valid"}, 32'(IFID_Valid), 32'd0);
    chk({tag, ".instr"}, IFID_Instruction, 32'h0);
    chk({tag, ".pcp4"}, IFID_PCPlus4, 32'h0);
    chk({tag, ".halted"}, 32'(Halted), 32'd0);
    chk({tag, ".count"}, 32'(FetchCount), 32'd0);
  endtask

  initial begin
    logic st, br, j;
    logic [31:0] bt, jt;
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000 + 32'(i);
    reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;

    step("boot", 0, 0, 0, 0, 0);
    step("seq0", 0, 0, 0, 0, 0);
    chk("seq0.lit_instr", IFID_Instruction, 32'h1000);
    chk("seq0.lit_pcp4", IFID_PCPlus4, 32'h0040_0004);
    step("seq1", 0, 0, 0, 0, 0);
    chk("seq1.lit_instr", IFID_Instruction, 32'h1001);
    chk("seq1.lit_pc", PC, 32'h0040_0008);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0, 0);
    chk("stall.lit_count", 32'(FetchCount), 32'd2);
    step("stall_jump", 1, 0, 0, 1, 32'h0040_0100);
    step("resume", 0, 0, 0, 0, 0);
    chk("resume.lit_pc", PC, 32'h0040_000C);

    step("br_prio", 1, 1, 32'h0040_0020, 1, 32'h0040_0100);
    chk("br_prio.lit_pc", PC, 32'h0040_0020);
    chk("br_prio.lit_valid", 32'(IFID_Valid), 32'd0);
    step("jump", 0, 0, 0, 1, 32'h0040_0040);
    chk("jump.lit_pc", PC, 32'h0040_0040);
    step("jump_fetch", 0, 0, 0, 0, 0);
    chk("jump_fetch.lit_instr", IFID_Instruction, 32'h1010);
    chk("jump_fetch.lit_pcp4", IFID_PCPlus4, 32'h0040_0044);

    step("misalign", 0, 1, 32'h0040_0022, 0, 0);
    step("misalign_fetch", 0, 0, 0, 0, 0);
    chk("misalign.lit_instr", IFID_Instruction, 32'h1008);

    step("to_end", 0, 0, 0, 1, 32'h0040_03F8);
    step("end254", 0, 0, 0, 0, 0);
    step("end255", 0, 0, 0, 0, 0);
    chk("end255.lit_instr", IFID_Instruction, 32'h10FF);
    step("halt", 0, 0, 0, 0, 0);
    chk("halt.lit_halted", 32'(Halted), 32'd1);
    chk("halt.lit_pc", PC, 32'h0040_0400);
    step("halt_ign", 1, 0, 0, 1, 32'h0040_0000);
    step("halt_oob_br", 0, 1, 32'h0030_0000, 0, 0);
    chk("halt_oob.lit_pc", PC, 32'h0030_0000);
    step("halt_wrap_br", 0, 1, 32'hFFFF_FFFC, 0, 0);
    step("restart", 0, 1, 32'h0040_0010, 0, 0);
    chk("restart.lit_halted", 32'(Halted), 32'd0);
    step("restart_fetch", 0, 0, 0, 0, 0);
    chk("restart.lit_instr", IFID_Instruction, 32'h1004);

    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 3) == 0);
      if (!m_boot && !m_halt && !inside_image(m_pc)) st = 1'b0;
      br = ($urandom_range(0, 9) == 0);
      j  = ($urandom_range(0, 9) == 0);
      bt = ($urandom_range(0, 15) == 0) ? $urandom() : BASE + 32'($urandom_range(0, 255) << 2);
      jt = BASE + 32'($urandom_range(0, 1023));
      step("rand", st, br, bt, j, jt);
    end

    step("pre_ar", 0, 1, 32'h0040_0100, 0, 0);
    step("pre_ar2", 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step("post_boot", 0, 0, 0, 0, 0);
    step("post_fetch", 0, 0, 0, 0, 0);
    chk("post_fetch.lit_instr", IFID_Instruction, 32'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch for the pipelined MIPS core. It owns the program counter, drives the byte address into the combinational program ROM and captures the returned word into the IF/ID pipeline register. It applies stall, branch/jump redirect and flush requests from later stages, and halts fetch when the PC leaves the program image.

Parameters:
MEMORY_DEPTH, 256, program ROM depth in 32-bit words
DATA_WIDTH, 32, instruction/address width
TEXT_BASE, 32'h0040_0000, reset PC and base of the text segment
NOP, 32'h0000_0000, instruction injected on flush or bubble

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
Stall  input  1  hazard unit: hold PC and IF/ID
BranchTaken  input  1  EX stage: branch resolved taken
BranchTarget  input  32  EX-stage branch target byte address
Jump  input  1  ID stage: j/jal decoded
JumpTarget  input  32  ID-stage jump target byte address
Instruction  input  32  word returned combinationally by program ROM
ProgramAddress  output  32  ROM byte address = PC - TEXT_BASE
PC  output  32  current fetch PC
IFID_Instruction  output  32  registered instruction to ID
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  IF/ID holds a real instruction
Halted  output  1  fetch stopped, PC out of image
FetchCount  output  16  instructions delivered to ID, saturating

Behaviour:
- Reset (reset=0, async): PC=TEXT_BASE, IFID_Instruction=NOP, IFID_PCPlus4=0, IFID_Valid=0, Halted=0, FetchCount=0, state=BOOT.
- ProgramAddress is combinational from PC; the ROM word is sampled on the same edge (zero-wait ROM).
- States: BOOT, RUN, HALT.
- BOOT: one cycle after reset release. PC holds, IF/ID=bubble. The next state is RUN, so the first real fetch occurs in cycle 2.
- RUN next-PC priority, evaluated each rising edge:
  1. BranchTaken: PC<=BranchTarget; IF/ID<=NOP with Valid=0 (flush). This overrides Stall and Jump because the EX instruction is older.
  2. Jump (and not Stall): PC<=JumpTarget; IF/ID<=NOP with Valid=0. The delay slot is not executed.
  3. Stall: PC and all IF/ID fields hold; FetchCount holds.
  4. Otherwise: PC<=PC+4; IF/ID<=Instruction, PC+4, Valid=1; FetchCount+1 (saturates at 16'hFFFF).
- Jump with Stall asserted and no BranchTaken: treated as a stall. The jump is re-presented by ID after the stall.
- Out-of-range condition: (PC - TEXT_BASE) >= MEMORY_DEPTH*4, or PC < TEXT_BASE (unsigned compare).
  - If out of range in RUN with no redirect: state<=HALT, Halted=1, PC holds, IF/ID<=bubble.
  - The condition is evaluated on the current PC before fetch, so an out-of-range word is never delivered.
- HALT: PC holds; IF/ID=bubble every cycle; Stall and Jump are ignored. BranchTaken to an in-range target sets PC<=target, Halted<=0 and state<=RUN. BranchTaken to an out-of-range target stays in HALT with PC updated.
- PC bits [1:0] are always written as received. A misaligned target is not corrected, because the ROM ignores bits [1:0].
- All arithmetic is 32-bit modulo 2^32. PC+4 wrap falls out of range and halts.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

Test Plan:
- Reset, release, no stalls, ROM = sequential words 0x1000+i -> BOOT for 1 cycle, then IFID_Instruction 0x1000, 0x1001, ... with IFID_PCPlus4 0x00400004, 0x00400008, ...; FetchCount increments each cycle.
- Stall held 3 cycles at PC=0x00400008 -> PC, IF/ID and FetchCount frozen 3 cycles, then resume at 0x0040000C.
- BranchTaken=1, Target=0x00400020, with Stall=1 and Jump=1 in the same cycle -> next PC=0x00400020, IFID_Valid=0, IFID_Instruction=0.
- Jump to 0x00400040 alone -> PC=0x00400040 next cycle, one bubble, then ROM word 16 is delivered with IFID_PCPlus4=0x00400044.
- Run to PC=0x00400400 (MEMORY_DEPTH=256) -> Halted=1, PC frozen, IFID_Valid=0; a later BranchTaken to 0x00400010 -> Halted=0 and fetch resumes there.
- Assert reset asynchronously mid-cycle during RUN -> all outputs return to reset values before the next clock edge.
